// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for mem_port_arbiter: RV32 funct3 sizing codes, FSM states and the
// default starvation limit.
package mem_port_arbiter_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned StarveLimitDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRespIf,
    StRespDm
  } arb_state_e;

  // Halfwords need addr[0] clear; words need addr[1:0] clear.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      F3_B, F3_BU: mis = 1'b0;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and backend signal bundle for mem_port_arbiter; the arbiter takes the slave
// modport, the pipeline/memory environment takes the master modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_valid;

  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_func3;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_valid;
  logic              dm_misalign;

  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func3;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, dm_rdata, dm_valid, dm_misalign,
    output mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, dm_rdata, dm_valid, dm_misalign,
    input  mem_read, mem_write, mem_func3, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive DM grants taken while a fetch was waiting.
module arb_streak_counter #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam int unsigned CntW = (Limit > 0) ? $clog2(Limit + 1) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_limit_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_limit_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: DM has priority over IF, with a streak limit against fetch
// starvation. Define MISALIGN_CHECK_EN to suppress misaligned DM accesses at the backend.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e  state_q, state_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        dm_mis_q, dm_mis_d;

  logic if_elig, dm_elig, grant_if, grant_dm, at_limit, dm_mis;

`ifdef MISALIGN_CHECK_EN
  assign dm_mis = is_misaligned(bus.dm_func3, bus.dm_addr[1:0]);
`else
  assign dm_mis = 1'b0;
`endif

  // A requester whose completion is showing this cycle sits out one cycle.
  always_comb begin
    if_elig  = bus.if_req && (state_q != StRespIf);
    dm_elig  = bus.dm_req && (state_q != StRespDm);
    grant_if = if_elig && (!dm_elig || at_limit);
    grant_dm = dm_elig && !grant_if;
  end

  arb_streak_counter #(
    .Limit(STARVE_LIMIT)
  ) u_streak (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (grant_dm && bus.if_req),
    .clr_i     (grant_if || !bus.if_req),
    .at_limit_o(at_limit)
  );

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_func3 = 3'd0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = 32'd0;
    // Gating on rst keeps a store granted as reset rises from reaching memory.
    if (!rst) begin
      if (grant_if) begin
        bus.mem_read  = 1'b1;
        bus.mem_func3 = F3_W;
        bus.mem_addr  = bus.if_addr;
      end else if (grant_dm) begin
        bus.mem_func3 = bus.dm_func3;
        bus.mem_addr  = bus.dm_addr;
        if (!dm_mis) begin
          if (bus.dm_we) begin
            bus.mem_write = 1'b1;
            bus.mem_wdata = bus.dm_wdata;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d    = StIdle;
    if_rdata_d = 32'd0;
    dm_rdata_d = 32'd0;
    dm_mis_d   = 1'b0;
    if (grant_if) begin
      state_d    = StRespIf;
      if_rdata_d = bus.mem_rdata;
    end else if (grant_dm) begin
      state_d  = StRespDm;
      dm_mis_d = dm_mis;
      if (!bus.dm_we && !dm_mis) begin
        dm_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
      dm_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      dm_mis_q   <= dm_mis_d;
    end
  end

  assign bus.if_valid    = (state_q == StRespIf);
  assign bus.dm_valid    = (state_q == StRespDm);
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.dm_misalign = dm_mis_q;

endmodule
